mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq.sv | 151 +++++++++++++++
 tb/tb_mul_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// mul_seq: sequencer between the instruction decoder and an external 8x8 multiplier.
// Issues the one-hot op, waits MUL_LAT cycles, then writes R0/R1 and C/Z to SREG.
module mul_seq #(
    parameter int MUL_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  req_op,
    input  logic        flush,
    output logic [5:0]  mu_op,
    input  logic [15:0] mu_ro,
    input  logic        mu_cf,
    input  logic        mu_zf,
    output logic        busy,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        sreg_we,
    output logic        c_out,
    output logic        z_out,
    output logic        done
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WB_LO, S_WB_HI} state_t;

    localparam logic [1:0] LP_LAT = 2'(MUL_LAT);

    state_t      r_state;
    logic [2:0]  r_op;
    logic [1:0]  r_cnt;
    logic [7:0]  r_res_hi;
    logic        r_cf;
    logic        r_zf;
    logic        r_wr_en;
    logic [4:0]  r_wr_addr;
    logic [7:0]  r_wr_data;
    logic        r_sreg_we;
    logic        r_c_out;
    logic        r_z_out;
    logic        r_done;
    logic        w_legal;
    logic        w_accept;

    function automatic logic [5:0] decode_op(input logic [2:0] op);
        logic [5:0] v;
        case (op)
            3'd0:    v = 6'b000001;
            3'd1:    v = 6'b000010;
            3'd2:    v = 6'b000100;
            3'd3:    v = 6'b001000;
            3'd4:    v = 6'b010000;
            3'd5:    v = 6'b100000;
            default: v = 6'b000000;
        endcase
        return v;
    endfunction

    assign w_legal  = (req_op <= 3'd5);
    assign w_accept = (r_state == S_IDLE) && req && !flush && w_legal;

    // The multiplier's input register samples on the accepting edge, so the op must be live that cycle.
    always_comb begin
        mu_op = 6'b000000;
        if (!reset) begin
            if (w_accept)
                mu_op = decode_op(req_op);
            else if (r_state == S_WAIT)
                mu_op = decode_op(r_op);
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign sreg_we = r_sreg_we;
    assign c_out   = r_c_out;
    assign z_out   = r_z_out;
    assign done    = r_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= 3'd0;
            r_cnt     <= 2'd0;
            r_res_hi  <= 8'd0;
            r_cf      <= 1'b0;
            r_zf      <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 5'd0;
            r_wr_data <= 8'd0;
            r_sreg_we <= 1'b0;
            r_c_out   <= 1'b0;
            r_z_out   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= 5'd0;
            r_wr_data <= 8'd0;
            r_sreg_we <= 1'b0;
            r_c_out   <= 1'b0;
            r_z_out   <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= req_op;
                        r_cnt   <= LP_LAT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 2'd1;
                    if (r_cnt == 2'd1) begin
                        r_res_hi <= mu_ro[15:8];
                        r_cf     <= mu_cf;
                        r_zf     <= mu_zf;
                    end
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 2'd1) begin
                        r_state   <= S_WB_LO;
                        r_wr_en   <= 1'b1;
                        r_wr_data <= mu_ro[7:0];
                    end
                end
                S_WB_LO: begin
                    // A flush here still lets this cycle's low-byte write stand; only WB_HI is dropped.
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state   <= S_WB_HI;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= 5'd1;
                        r_wr_data <= r_res_hi;
                        r_sreg_we <= 1'b1;
                        r_c_out   <= r_cf;
                        r_z_out   <= r_zf;
                        r_done    <= 1'b1;
                    end
                end
                S_WB_HI: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq with MUL_LAT=1 and a reference AVR-style multiplier attached.
module tb_mul_seq;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic        flush = 1'b0;
    logic [5:0]  mu_op;
    logic [15:0] mu_ro;
    logic        mu_cf;
    logic        mu_zf;
    logic        busy, wr_en, sreg_we, c_out, z_out, done;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  op_a = 8'd0;
    logic [7:0]  op_b = 8'd0;
    logic [7:0]  m_a = 8'd0;
    logic [7:0]  m_b = 8'd0;
    logic [5:0]  m_op = 6'd0;
    logic [18:0] obs;
    int          n_tests = 0;
    int          n_fail = 0;

    localparam logic [18:0] IDLE_OUT = 19'd0;
    localparam logic [18:0] WAIT_OUT = {1'b1, 1'b0, 5'd0, 8'h00, 4'b0000};

    mul_seq #(.MUL_LAT(1)) dut (
        .clock(clock), .reset(reset), .req(req), .req_op(req_op), .flush(flush),
        .mu_op(mu_op), .mu_ro(mu_ro), .mu_cf(mu_cf), .mu_zf(mu_zf), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sreg_we(sreg_we),
        .c_out(c_out), .z_out(z_out), .done(done)
    );

    always #5 clock = ~clock;

    // {busy, wr_en, wr_addr, wr_data, sreg_we, c_out, z_out, done}
    assign obs = {busy, wr_en, wr_addr, wr_data, sreg_we, c_out, z_out, done};

    // Reference multiplier: input register loads whenever an op is presented.
    always @(posedge clock) begin
        if (mu_op != 6'd0) begin
            m_a  <= op_a;
            m_b  <= op_b;
            m_op <= mu_op;
        end
    end

    always_comb begin
        int ea, eb, p;
        logic [15:0] r16;
        logic sa, sb, frac;
        sa   = m_op[1] | m_op[2] | m_op[4] | m_op[5];
        sb   = m_op[1] | m_op[4];
        frac = m_op[3] | m_op[4] | m_op[5];
        ea   = sa ? int'($signed(m_a)) : int'(m_a);
        eb   = sb ? int'($signed(m_b)) : int'(m_b);
        p    = ea * eb;
        r16  = p[15:0];
        mu_cf = r16[15];
        mu_ro = frac ? {r16[14:0], 1'b0} : r16;
        if (m_op == 6'd0) begin
            mu_cf = 1'b0;
            mu_ro = 16'd0;
        end
        mu_zf = (mu_ro == 16'd0);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req = 1'b1; req_op = op; op_a = a; op_b = b;
    endtask

    task automatic test_reset();
        req = 1'b1; req_op = 3'd0; op_a = 8'hFF; op_b = 8'hFF;
        #3;
        n_tests++; if (obs !== IDLE_OUT) begin n_fail++; $display("FAIL reset_async_out: got %h want %h", obs, IDLE_OUT); end
        n_tests++; if (mu_op !== 6'd0) begin n_fail++; $display("FAIL reset_mu_op: got %b want %b", mu_op, 6'd0); end
        tick();
        n_tests++; if (obs !== IDLE_OUT) begin n_fail++; $display("FAIL reset_held_out: got %h want %h", obs, IDLE_OUT); end
        reset = 1'b0; req = 1'b0;
        tick();
        n_tests++; if (obs !== IDLE_OUT) begin n_fail++; $display("FAIL reset_release_idle: got %h want %h", obs, IDLE_OUT); end
    endtask

    task automatic test_mul_ff();
        start(3'd0, 8'hFF, 8'hFF); #1;
        n_tests++; if (mu_op !== 6'b000001) begin n_fail++; $display("FAIL mul_ff_mu_op_c0: got %b want %b", mu_op, 6'b000001); end
        tick(); req = 1'b0;
        n_tests++; if (obs !== WAIT_OUT) begin n_fail++; $display("FAIL mul_ff_c1: got %h want %h", obs, WAIT_OUT); end
        n_tests++; if (mu_op !== 6'b000001) begin n_fail++; $display("FAIL mul_ff_mu_op_c1: got %b want %b", mu_op, 6'b000001); end
        tick();
        n_tests++; if (obs !== {1'b1, 1'b1, 5'd0, 8'h01, 4'b0000}) begin n_fail++; $display("FAIL mul_ff_c2: got %h want %h", obs, {1'b1, 1'b1, 5'd0, 8'h01, 4'b0000}); end
        n_tests++; if (mu_op !== 6'd0) begin n_fail++; $display("FAIL mul_ff_mu_op_c2: got %b want %b", mu_op, 6'd0); end
        tick();
        n_tests++; if (obs !== {1'b1, 1'b1, 5'd1, 8'hFE, 4'b1101}) begin n_fail++; $display("FAIL mul_ff_c3: got %h want %h", obs, {1'b1, 1'b1, 5'd1, 8'hFE, 4'b1101}); end
        tick();
        n_tests++; if (obs !== IDLE_OUT) begin n_fail++; $display("FAIL mul_ff_c4: got %h want %h", obs, IDLE_OUT); end
    endtask

    task automatic test_muls();
        start(3'd1, 8'h80, 8'h80); #1;
        n_tests++; if (mu_op !== 6'b000010) begin n_fail++; $display("FAIL muls_mu_op: got %b want %b", mu_op, 6'b000010); end
        tick(); req = 1'b0;
        tick();
        n_tests++; if (obs !== {1'b1, 1'b1, 5'd0, 8'h00, 4'b0000}) begin n_fail++; $display("FAIL muls_c2: got %h want %h", obs, {1'b1, 1'b1, 5'd0, 8'h00, 4'b0000}); end
        tick();
        n_tests++; if (obs !== {1'b1, 1'b1, 5'd1, 8'h40, 4'b1001}) begin n_fail++; $display("FAIL muls_c3: got %h want %h", obs, {1'b1, 1'b1, 5'd1, 8'h40, 4'b1001}); end
        tick();
    endtask

    task automatic test_fmul();
        start(3'd3, 8'h80, 8'h80); #1;
        n_tests++; if (mu_op !== 6'b001000) begin n_fail++; $display("FAIL fmul_mu_op: got %b want %b", mu_op, 6'b001000); end
        tick(); req = 1'b0;
        tick();
        n_tests++; if (obs !== {1'b1, 1'b1, 5'd0, 8'h00, 4'b0000}) begin n_fail++; $display("FAIL fmul_c2: got %h want %h", obs, {1'b1, 1'b1, 5'd0, 8'h00, 4'b0000}); end
        tick();
        n_tests++; if (obs !== {1'b1, 1'b1, 5'd1, 8'h80, 4'b1001}) begin n_fail++; $display("FAIL fmul_c3: got %h want %h", obs, {1'b1, 1'b1, 5'd1, 8'h80, 4'b1001}); end
        tick();
    endtask

    task automatic test_mulsu();
        start(3'd2, 8'hFF, 8'h02); #1;
        n_tests++; if (mu_op !== 6'b000100) begin n_fail++; $display("FAIL mulsu_mu_op: got %b want %b", mu_op, 6'b000100); end
        tick(); req = 1'b0;
        tick();
        n_tests++; if (obs !== {1'b1, 1'b1, 5'd0, 8'hFE, 4'b0000}) begin n_fail++; $display("FAIL mulsu_c2: got %h want %h", obs, {1'b1, 1'b1, 5'd0, 8'hFE, 4'b0000}); end
        tick();
        n_tests++; if (obs !== {1'b1, 1'b1, 5'd1, 8'hFF, 4'b1101}) begin n_fail++; $display("FAIL mulsu_c3: got %h want %h", obs, {1'b1, 1'b1, 5'd1, 8'hFF, 4'b1101}); end
        tick();
    endtask

    task automatic test_back_to_back();
        start(3'd0, 8'h00, 8'h55);
        tick(); req = 1'b0;
        tick();
        n_tests++; if (obs !== {1'b1, 1'b1, 5'd0, 8'h00, 4'b0000}) begin n_fail++; $display("FAIL zero_c2: got %h want %h", obs, {1'b1, 1'b1, 5'd0, 8'h00, 4'b0000}); end
        req = 1'b1; req_op = 3'd0; #1;
        n_tests++; if (mu_op !== 6'd0) begin n_fail++; $display("FAIL busy_req_mu_op: got %b want %b", mu_op, 6'd0); end
        tick(); req = 1'b0;
        n_tests++; if (obs !== {1'b1, 1'b1, 5'd1, 8'h00, 4'b1011}) begin n_fail++; $display("FAIL zero_c3: got %h want %h", obs, {1'b1, 1'b1, 5'd1, 8'h00, 4'b1011}); end
        tick();
        n_tests++; if (obs !== IDLE_OUT) begin n_fail++; $display("FAIL busy_req_ignored_c4: got %h want %h", obs, IDLE_OUT); end
        start(3'd0, 8'h02, 8'h03); #1;
        n_tests++; if (mu_op !== 6'b000001) begin n_fail++; $display("FAIL b2b_accept_c4: got %b want %b", mu_op, 6'b000001); end
        tick(); req = 1'b0;
        n_tests++; if (obs !== WAIT_OUT) begin n_fail++; $display("FAIL b2b_c5: got %h want %h", obs, WAIT_OUT); end
        tick();
        n_tests++; if (obs !== {1'b1, 1'b1, 5'd0, 8'h06, 4'b0000}) begin n_fail++; $display("FAIL b2b_c6: got %h want %h", obs, {1'b1, 1'b1, 5'd0, 8'h06, 4'b0000}); end
        tick();
        n_tests++; if (obs !== {1'b1, 1'b1, 5'd1, 8'h00, 4'b1001}) begin n_fail++; $display("FAIL b2b_c7: got %h want %h", obs, {1'b1, 1'b1, 5'd1, 8'h00, 4'b1001}); end
        tick();
    endtask

    task automatic test_flush();
        start(3'd2, 8'h10, 8'h10);
        tick(); req = 1'b0; flush = 1'b1;
        n_tests++; if (obs !== WAIT_OUT) begin n_fail++; $display("FAIL flush_wait_c1: got %h want %h", obs, WAIT_OUT); end
        tick(); flush = 1'b0;
        n_tests++; if (obs !== IDLE_OUT) begin n_fail++; $display("FAIL flush_wait_c2: got %h want %h", obs, IDLE_OUT); end
        tick();
        n_tests++; if (obs !== IDLE_OUT) begin n_fail++; $display("FAIL flush_wait_c3: got %h want %h", obs, IDLE_OUT); end
        req = 1'b1; req_op = 3'b111; #1;
        n_tests++; if (mu_op !== 6'd0) begin n_fail++; $display("FAIL illegal_mu_op: got %b want %b", mu_op, 6'd0); end
        tick(); req = 1'b0;
        n_tests++; if (obs !== IDLE_OUT) begin n_fail++; $display("FAIL illegal_busy: got %h want %h", obs, IDLE_OUT); end
        start(3'd0, 8'h05, 8'h05); flush = 1'b1; #1;
        n_tests++; if (mu_op !== 6'd0) begin n_fail++; $display("FAIL flush_req_mu_op: got %b want %b", mu_op, 6'd0); end
        tick(); req = 1'b0; flush = 1'b0;
        n_tests++; if (obs !== IDLE_OUT) begin n_fail++; $display("FAIL flush_req_dropped: got %h want %h", obs, IDLE_OUT); end
        start(3'd0, 8'hFF, 8'hFF);
        tick(); req = 1'b0;
        tick(); flush = 1'b1;
        n_tests++; if (obs !== {1'b1, 1'b1, 5'd0, 8'h01, 4'b0000}) begin n_fail++; $display("FAIL flush_wblo_write: got %h want %h", obs, {1'b1, 1'b1, 5'd0, 8'h01, 4'b0000}); end
        tick(); flush = 1'b0;
        n_tests++; if (obs !== IDLE_OUT) begin n_fail++; $display("FAIL flush_wblo_no_hi: got %h want %h", obs, IDLE_OUT); end
        start(3'd0, 8'hFF, 8'hFF);
        tick(); req = 1'b0;
        tick();
        tick(); flush = 1'b1;
        n_tests++; if (obs !== {1'b1, 1'b1, 5'd1, 8'hFE, 4'b1101}) begin n_fail++; $display("FAIL flush_wbhi_done: got %h want %h", obs, {1'b1, 1'b1, 5'd1, 8'hFE, 4'b1101}); end
        tick(); flush = 1'b0;
        n_tests++; if (obs !== IDLE_OUT) begin n_fail++; $display("FAIL flush_wbhi_idle: got %h want %h", obs, IDLE_OUT); end
    endtask

    task automatic test_reset_mid();
        start(3'd0, 8'hFF, 8'hFF);
        tick(); req = 1'b0;
        tick();
        n_tests++; if (obs !== {1'b1, 1'b1, 5'd0, 8'h01, 4'b0000}) begin n_fail++; $display("FAIL rst_mid_wblo: got %h want %h", obs, {1'b1, 1'b1, 5'd0, 8'h01, 4'b0000}); end
        #1 reset = 1'b1;
        #1;
        n_tests++; if (obs !== IDLE_OUT) begin n_fail++; $display("FAIL rst_mid_async: got %h want %h", obs, IDLE_OUT); end
        tick();
        n_tests++; if (obs !== IDLE_OUT) begin n_fail++; $display("FAIL rst_mid_no_r1: got %h want %h", obs, IDLE_OUT); end
        reset = 1'b0;
        start(3'd0, 8'h02, 8'h03); #1;
        n_tests++; if (mu_op !== 6'b000001) begin n_fail++; $display("FAIL rst_mid_accept: got %b want %b", mu_op, 6'b000001); end
        tick(); req = 1'b0;
        n_tests++; if (obs !== WAIT_OUT) begin n_fail++; $display("FAIL rst_mid_wait: got %h want %h", obs, WAIT_OUT); end
        tick();
        n_tests++; if (obs !== {1'b1, 1'b1, 5'd0, 8'h06, 4'b0000}) begin n_fail++; $display("FAIL rst_mid_r0: got %h want %h", obs, {1'b1, 1'b1, 5'd0, 8'h06, 4'b0000}); end
        tick();
        n_tests++; if (obs !== {1'b1, 1'b1, 5'd1, 8'h00, 4'b1001}) begin n_fail++; $display("FAIL rst_mid_r1: got %h want %h", obs, {1'b1, 1'b1, 5'd1, 8'h00, 4'b1001}); end
        tick();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul_ff();
        test_muls();
        test_fmul();
        test_mulsu();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
